load_store_unit: RTL and testbench

Core-side initiator for the word-organised data memory. It accepts one load or store per request from the execute stage and generates the memory's `dmem_sel`/`wr`/`mask`/`addr`/`dmem_data_wr` controls, steering store bytes onto the correct lanes. Load data is extracted and sign- or zero-extended. Misaligned halfword and word accesses are split into two word beats by a small state machine. The unit sits between the pipeline's memory stage and the data memory, and stalls the pipeline while it is busy.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// the byte-enable pattern helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } lsu_state_t;

   // Unshifted byte-enable pattern for an access width; unsigned variants
   // share the pattern of their signed counterparts.
   function automatic logic [3:0] width_pattern(input logic [2:0] f3);
      logic [3:0] pat;
      case (f3[1:0])
         2'b00:   pat = 4'b0001;
         2'b01:   pat = 4'b0011;
         2'b10:   pat = 4'b1111;
         default: pat = 4'b0000;
      endcase
      return pat;
   endfunction

   // Width codes the unit refuses: reserved encodings, and unsigned widths on stores.
   function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
      logic bad;
      case (f3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = is_store;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte-enables/data placement across a
// two-word window, split detection, and load extract/extend from {hi,lo}.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   output logic [7:0]  m8_o,
   output logic [63:0] d64_o,
   output logic        split_o,
   output logic [31:0] rdata_o
);

   logic [63:0] window;
   logic [31:0] raw;

   // Place store lanes, detect word-crossing accesses and extend load data.
   always_comb begin
      m8_o    = {4'b0000, width_pattern(funct3_i)} << off_i;
      d64_o   = {32'b0, wdata_i} << {off_i, 3'b000};
      split_o = ((funct3_i[1:0] == 2'b01) && (off_i == 2'd3)) ||
                ((funct3_i[1:0] == 2'b10) && (off_i != 2'd0));
      window  = {hi_i, lo_i} >> {off_i, 3'b000};
      raw     = window[31:0];
      case (funct3_i)
         F3_B:    rdata_o = {{24{raw[7]}}, raw[7:0]};
         F3_H:    rdata_o = {{16{raw[15]}}, raw[15:0]};
         F3_W:    rdata_o = raw;
         F3_BU:   rdata_o = {24'b0, raw[7:0]};
         F3_HU:   rdata_o = {16'b0, raw[15:0]};
         default: rdata_o = 32'b0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, drives one or two word
// beats to the data memory and returns a single-cycle response.
//
// state | meaning
// IDLE  | ready for a request; captures it on req_valid
// BEAT0 | first (or only) word access at the aligned base address
// BEAT1 | second word access for accesses crossing a word boundary
// RESP  | one-cycle response pulse with extended load data / error flag
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              dmem_sel,
   output logic              wr,
   output logic [3:0]        mask,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       dmem_data_wr,
   input  logic [31:0]       dmem_data_rd
);

   lsu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [2:0]        f3_q, f3_d;
   logic              err_q, err_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       hi_q, hi_d;

   logic [7:0]        m8;
   logic [63:0]       d64;
   logic              split;
   logic [31:0]       ext_rdata;
   logic [ADDR_W-3:0] word0, word1;

   assign word0 = addr_q[ADDR_W-1:2];
   assign word1 = word0 + {{(ADDR_W-3){1'b0}}, 1'b1};

   lsu_lane_align u_align (
      .off_i    (addr_q[1:0]),
      .funct3_i (f3_q),
      .wdata_i  (wdata_q),
      .lo_i     (lo_q),
      .hi_i     (hi_q),
      .m8_o     (m8),
      .d64_o    (d64),
      .split_o  (split),
      .rdata_o  (ext_rdata)
   );

   // State and request registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         last_addr_q <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         f3_q        <= 3'b000;
         err_q       <= 1'b0;
         lo_q        <= '0;
         hi_q        <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         last_addr_q <= last_addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         f3_q        <= f3_d;
         err_q       <= err_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
      end
   end

   // Next-state and memory/response outputs; addr holds the last beat address.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      last_addr_d  = last_addr_q;
      wdata_d      = wdata_q;
      wr_d         = wr_q;
      f3_d         = f3_q;
      err_d        = err_q;
      lo_d         = lo_q;
      hi_d         = hi_q;
      dmem_sel     = 1'b0;
      wr           = 1'b0;
      mask         = 4'b0000;
      addr         = last_addr_q;
      dmem_data_wr = 32'b0;
      resp_valid   = 1'b0;
      resp_err     = 1'b0;
      resp_rdata   = 32'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wr_d    = req_wr;
               f3_d    = req_funct3;
               lo_d    = '0;
               hi_d    = '0;
               err_d   = f3_illegal(req_funct3, req_wr);
               state_d = f3_illegal(req_funct3, req_wr) ? RESP : BEAT0;
            end
         end
         BEAT0: begin
            dmem_sel     = 1'b1;
            wr           = wr_q;
            addr         = {word0, 2'b00};
            mask         = wr_q ? m8[3:0] : 4'b0000;
            dmem_data_wr = d64[31:0];
            last_addr_d  = {word0, 2'b00};
            if (!wr_q) lo_d = dmem_data_rd;
            state_d      = split ? BEAT1 : RESP;
         end
         BEAT1: begin
            dmem_sel     = 1'b1;
            wr           = wr_q;
            addr         = {word1, 2'b00};
            mask         = wr_q ? m8[7:4] : 4'b0000;
            dmem_data_wr = d64[63:32];
            last_addr_d  = {word1, 2'b00};
            if (!wr_q) hi_d = dmem_data_rd;
            state_d      = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (!wr_q && !err_q) ? ext_rdata : 32'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready = rst && (state_q == IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane word memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        dmem_sel, wr;
   logic [3:0]  mask;
   logic [31:0] addr, dmem_data_wr, dmem_data_rd;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wr       (req_wr),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .dmem_sel     (dmem_sel),
      .wr           (wr),
      .mask         (mask),
      .addr         (addr),
      .dmem_data_wr (dmem_data_wr),
      .dmem_data_rd (dmem_data_rd)
   );

   // Memory model: byte-lane writes on negedge, combinational read.
   always @(negedge clk) begin
      if (dmem_sel && wr) begin
         for (int i = 0; i < 4; i++)
            if (mask[i]) mem[addr[7:2]][8*i +: 8] <= dmem_data_wr[8*i +: 8];
      end
   end
   assign dmem_data_rd = mem[addr[7:2]];

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int          lat;
      logic        err;
      logic [31:0] rd;
      int          nb;
      logic [31:0] a0;
      logic [3:0]  m0;
      logic [31:0] d0;
      logic [31:0] a1;
      logic [3:0]  m1;
      logic [31:0] d1;
   } vec_t;

   localparam int NV = 32;
   vec_t vt [0:NV-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_req(input vec_t v, input int idx);
      int          guard;
      int          nb;
      int          lat;
      logic [31:0] ba [0:1];
      logic [3:0]  bm [0:1];
      logic [31:0] bd [0:1];
      logic        bw [0:1];
      logic [31:0] rr;
      logic        re;
      string       tag;
      tag   = $sformatf("v%0d", idx);
      guard = 0;
      while (!req_ready && guard < 10) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!req_ready) chk({tag, " ready_timeout"}, 32'd0, 32'd1);
      req_valid  = 1'b1;
      req_wr     = v.wr;
      req_funct3 = v.f3;
      req_addr   = v.a;
      req_wdata  = v.wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_wdata = 32'h0;
      nb  = 0;
      lat = 0;
      rr  = 32'h0;
      re  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ba[i] = 32'h0; bm[i] = 4'h0; bd[i] = 32'h0; bw[i] = 1'b0;
      end
      for (int k = 1; k <= 6; k++) begin
         if (dmem_sel) begin
            if (nb < 2) begin
               ba[nb] = addr; bm[nb] = mask; bd[nb] = dmem_data_wr; bw[nb] = wr;
            end
            nb++;
         end
         if (resp_valid) begin
            lat = k; rr = resp_rdata; re = resp_err;
            break;
         end
         @(posedge clk); #1;
      end
      chk({tag, " resp_latency"}, lat, v.lat);
      chk({tag, " resp_err"}, {31'b0, re}, {31'b0, v.err});
      chk({tag, " resp_rdata"}, rr, v.rd);
      chk({tag, " beats"}, nb, v.nb);
      if (v.nb >= 1) begin
         chk({tag, " b0_addr"}, ba[0], v.a0);
         chk({tag, " b0_mask"}, {28'b0, bm[0]}, {28'b0, v.m0});
         chk({tag, " b0_data"}, bd[0], v.d0);
         chk({tag, " b0_wr"}, {31'b0, bw[0]}, {31'b0, v.wr});
      end
      if (v.nb == 2) begin
         chk({tag, " b1_addr"}, ba[1], v.a1);
         chk({tag, " b1_wr"}, {31'b0, bw[1]}, {31'b0, v.wr});
         if (v.wr) begin
            chk({tag, " b1_mask"}, {28'b0, bm[1]}, {28'b0, v.m1});
            chk({tag, " b1_data"}, bd[1], v.d1);
         end
      end
      if (lat != 0) begin
         @(posedge clk); #1;
         chk({tag, " ready_after"}, {31'b0, req_ready}, 32'd1);
         chk({tag, " resp_pulse_end"}, {31'b0, resp_valid}, 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //          wr    f3      addr          wdata         lat err   rdata         nb a0            m0     d0            a1            m1     d1
      vt[0]  = '{1'b1, 3'b010, 32'h00000008, 32'hDEADBEEF, 2, 1'b0, 32'h00000000, 1, 32'h00000008, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0};
      vt[1]  = '{1'b1, 3'b010, 32'h0000000C, 32'h00000000, 2, 1'b0, 32'h00000000, 1, 32'h0000000C, 4'hF, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[2]  = '{1'b1, 3'b000, 32'h0000000D, 32'h000000A5, 2, 1'b0, 32'h00000000, 1, 32'h0000000C, 4'h2, 32'h0000A500, 32'h0, 4'h0, 32'h0};
      vt[3]  = '{1'b0, 3'b100, 32'h0000000D, 32'h00000000, 2, 1'b0, 32'h000000A5, 1, 32'h0000000C, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[4]  = '{1'b0, 3'b000, 32'h0000000D, 32'h00000000, 2, 1'b0, 32'hFFFFFFA5, 1, 32'h0000000C, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[5]  = '{1'b1, 3'b010, 32'h00000010, 32'h80017F00, 2, 1'b0, 32'h00000000, 1, 32'h00000010, 4'hF, 32'h80017F00, 32'h0, 4'h0, 32'h0};
      vt[6]  = '{1'b0, 3'b001, 32'h00000012, 32'h00000000, 2, 1'b0, 32'hFFFF8001, 1, 32'h00000010, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[7]  = '{1'b0, 3'b101, 32'h00000012, 32'h00000000, 2, 1'b0, 32'h00008001, 1, 32'h00000010, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[8]  = '{1'b0, 3'b001, 32'h00000010, 32'h00000000, 2, 1'b0, 32'h00007F00, 1, 32'h00000010, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[9]  = '{1'b1, 3'b010, 32'h00000004, 32'h000000CC, 2, 1'b0, 32'h00000000, 1, 32'h00000004, 4'hF, 32'h000000CC, 32'h0, 4'h0, 32'h0};
      vt[10] = '{1'b1, 3'b010, 32'h00000005, 32'h11223344, 3, 1'b0, 32'h00000000, 2, 32'h00000004, 4'hE, 32'h22334400, 32'h00000008, 4'h1, 32'h00000011};
      vt[11] = '{1'b0, 3'b010, 32'h00000004, 32'h00000000, 2, 1'b0, 32'h223344CC, 1, 32'h00000004, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[12] = '{1'b0, 3'b010, 32'h00000008, 32'h00000000, 2, 1'b0, 32'hDEADBE11, 1, 32'h00000008, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[13] = '{1'b1, 3'b010, 32'h0000000C, 32'hAABBCCDD, 2, 1'b0, 32'h00000000, 1, 32'h0000000C, 4'hF, 32'hAABBCCDD, 32'h0, 4'h0, 32'h0};
      vt[14] = '{1'b1, 3'b010, 32'h00000010, 32'h11223344, 2, 1'b0, 32'h00000000, 1, 32'h00000010, 4'hF, 32'h11223344, 32'h0, 4'h0, 32'h0};
      vt[15] = '{1'b0, 3'b010, 32'h0000000E, 32'h00000000, 3, 1'b0, 32'h3344AABB, 2, 32'h0000000C, 4'h0, 32'h00000000, 32'h00000010, 4'h0, 32'h0};
      vt[16] = '{1'b0, 3'b001, 32'h0000000F, 32'h00000000, 3, 1'b0, 32'h000044AA, 2, 32'h0000000C, 4'h0, 32'h00000000, 32'h00000010, 4'h0, 32'h0};
      vt[17] = '{1'b0, 3'b011, 32'h00000000, 32'h00000000, 1, 1'b1, 32'h00000000, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[18] = '{1'b1, 3'b100, 32'h00000004, 32'h000000FF, 1, 1'b1, 32'h00000000, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[19] = '{1'b0, 3'b110, 32'h00000000, 32'h00000000, 1, 1'b1, 32'h00000000, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[20] = '{1'b0, 3'b101, 32'h00000011, 32'h00000000, 2, 1'b0, 32'h00002233, 1, 32'h00000010, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[21] = '{1'b0, 3'b100, 32'h00000013, 32'h00000000, 2, 1'b0, 32'h00000011, 1, 32'h00000010, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[22] = '{1'b1, 3'b001, 32'h0000000B, 32'h0000BEEF, 3, 1'b0, 32'h00000000, 2, 32'h00000008, 4'h8, 32'hEF000000, 32'h0000000C, 4'h1, 32'h000000BE};
      vt[23] = '{1'b0, 3'b010, 32'h0000000C, 32'h00000000, 2, 1'b0, 32'hAABBCCBE, 1, 32'h0000000C, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[24] = '{1'b0, 3'b010, 32'h00000008, 32'h00000000, 2, 1'b0, 32'hEFADBE11, 1, 32'h00000008, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[25] = '{1'b1, 3'b010, 32'h00000000, 32'h00000000, 2, 1'b0, 32'h00000000, 1, 32'h00000000, 4'hF, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[26] = '{1'b1, 3'b010, 32'hFFFFFFFC, 32'h00000000, 2, 1'b0, 32'h00000000, 1, 32'hFFFFFFFC, 4'hF, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[27] = '{1'b1, 3'b010, 32'hFFFFFFFD, 32'h55667788, 3, 1'b0, 32'h00000000, 2, 32'hFFFFFFFC, 4'hE, 32'h66778800, 32'h00000000, 4'h1, 32'h00000055};
      vt[28] = '{1'b0, 3'b010, 32'hFFFFFFFD, 32'h00000000, 3, 1'b0, 32'h55667788, 2, 32'hFFFFFFFC, 4'h0, 32'h00000000, 32'h00000000, 4'h0, 32'h0};
      vt[29] = '{1'b1, 3'b010, 32'h00000020, 32'h00000000, 2, 1'b0, 32'h00000000, 1, 32'h00000020, 4'hF, 32'h00000000, 32'h0, 4'h0, 32'h0};
      vt[30] = '{1'b1, 3'b111, 32'h00000020, 32'h12345678, 1, 1'b1, 32'h00000000, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vt[31] = '{1'b0, 3'b000, 32'h0000000E, 32'h00000000, 2, 1'b0, 32'hFFFFFFBB, 1, 32'h0000000C, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};

      rst        = 1'b0;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset req_ready", {31'b0, req_ready}, 32'd0);
      chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("reset dmem_sel", {31'b0, dmem_sel}, 32'd0);
      chk("reset mask", {28'b0, mask}, 32'd0);
      chk("reset addr", addr, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("release req_ready", {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < NV; i++) run_req(vt[i], i);

      // Reset during the second beat of a split store.
      req_valid  = 1'b1;
      req_wr     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h00000021;
      req_wdata  = 32'h11223344;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      chk("rst_seq beat0 sel", {31'b0, dmem_sel}, 32'd1);
      chk("rst_seq beat0 addr", addr, 32'h00000020);
      chk("rst_seq busy ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rst_seq beat1 addr", addr, 32'h00000024);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_seq sel after", {31'b0, dmem_sel}, 32'd0);
      chk("rst_seq no resp", {31'b0, resp_valid}, 32'd0);
      chk("rst_seq ready low", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rst_seq no resp 2", {31'b0, resp_valid}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_seq ready back", {31'b0, req_ready}, 32'd1);
      chk("rst_seq no resp 3", {31'b0, resp_valid}, 32'd0);

      // BEAT0 lanes of the abandoned store remain in memory.
      v = '{1'b0, 3'b010, 32'h00000020, 32'h00000000, 2, 1'b0, 32'h22334400, 1, 32'h00000020, 4'h0, 32'h00000000, 32'h0, 4'h0, 32'h0};
      run_req(v, 100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
